rf_arbiter: RTL

Two-port arbiter sharing the single-write-port, single-read-port register file (4 x 8 default) between the core datapath (requester 0) and the host load/debug port (requester 1). Accepts one read or write per cycle via valid/ready handshakes, drives the register file's rd/wr/address/data pins, and returns read data one cycle later. Round-robin fairness, optional lock for multi-beat sequences, and a lock timeout against starvation.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_rr_pick.sv | 31 +++
 rtl/rf_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file arbiter.
//   - default register-file geometry (address width, data width) and lock limit
//   - arbiter FSM state encoding
//   - requester id constants
package rf_pkg;

   localparam int NUMRF_DEF    = 2;
   localparam int SIZE_DEF     = 8;
   localparam int MAX_LOCK_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_e;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/rf_rr_pick.sv
// rf_rr_pick: combinational 2-way round-robin grant select.
// Ports:
//   valid_i [1:0] : request valids (bit 0 = core, bit 1 = host)
//   last_i        : id of the most recently granted requester
//   state_i       : arbiter lock state; while owned, only the owner may win
//   grant_o [1:0] : one-hot grant, or zero when nothing is granted
module rf_rr_pick
   import rf_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       last_i,
   input  state_e     state_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      case (state_i)
         ST_OWN0: grant_o = {1'b0, valid_i[REQ_CORE]};
         ST_OWN1: grant_o = {valid_i[REQ_HOST], 1'b0};
         default: begin
            // On a tie the requester that did not go last wins.
            if (valid_i == 2'b11)
               grant_o = (last_i == REQ_HOST) ? 2'b01 : 2'b10;
            else
               grant_o = valid_i;
         end
      endcase
   end

endmodule

// File: rtl/rf_arbiter.sv
// rf_arbiter: shares a 1R/1W register file between the core datapath
// (requester 0) and the host load/debug port (requester 1).
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   reqN_valid/we/lock/addr/wdata : requester N transaction (N = 0,1)
//   reqN_ready                  : transaction accepted this cycle
//   reqN_rvalid/rdata           : read data, one cycle after an accepted read
//   rf_rd/rf_wr                 : register file strobes
//   rf_reg_out/rf_reg_in        : register file read / write index
//   rf_data_in/rf_data_out      : register file write data / async read data
//   owner                       : {locked, last granted id}
module rf_arbiter
   import rf_pkg::*;
#(
   parameter int NUMRF    = NUMRF_DEF,
   parameter int SIZE     = SIZE_DEF,
   parameter int MAX_LOCK = MAX_LOCK_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic             req0_we,
   input  logic             req0_lock,
   input  logic [NUMRF-1:0] req0_addr,
   input  logic [SIZE-1:0]  req0_wdata,
   output logic             req0_ready,
   output logic             req0_rvalid,
   output logic [SIZE-1:0]  req0_rdata,
   input  logic             req1_valid,
   input  logic             req1_we,
   input  logic             req1_lock,
   input  logic [NUMRF-1:0] req1_addr,
   input  logic [SIZE-1:0]  req1_wdata,
   output logic             req1_ready,
   output logic             req1_rvalid,
   output logic [SIZE-1:0]  req1_rdata,
   output logic             rf_rd,
   output logic             rf_wr,
   output logic [NUMRF-1:0] rf_reg_out,
   output logic [NUMRF-1:0] rf_reg_in,
   output logic [SIZE-1:0]  rf_data_in,
   input  logic [SIZE-1:0]  rf_data_out,
   output logic [1:0]       owner
);

   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              last_q, last_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic [SIZE-1:0]   rdata0_q, rdata0_d;
   logic [SIZE-1:0]   rdata1_q, rdata1_d;

   logic [1:0]        pick;
   logic [1:0]        grant;
   logic              any;
   logic              sel;
   logic              sel_we;
   logic              sel_lock;
   logic [NUMRF-1:0]  sel_addr;
   logic [SIZE-1:0]   sel_wdata;
   logic              own_id;

   rf_rr_pick u_pick (
      .valid_i ({req1_valid, req0_valid}),
      .last_i  (last_q),
      .state_i (state_q),
      .grant_o (pick)
   );

   // Grant is masked by reset so no register-file access leaks out while
   // rst_n is low, including the cycle in which reset is asserted.
   assign grant      = pick & {2{rst_n}};
   assign any        = |grant;
   assign sel        = grant[REQ_HOST];
   assign sel_we     = sel ? req1_we    : req0_we;
   assign sel_lock   = sel ? req1_lock  : req0_lock;
   assign sel_addr   = sel ? req1_addr  : req0_addr;
   assign sel_wdata  = sel ? req1_wdata : req0_wdata;

   assign req0_ready = grant[REQ_CORE];
   assign req1_ready = grant[REQ_HOST];

   always_comb begin
      rf_rd      = 1'b0;
      rf_wr      = 1'b0;
      rf_reg_out = '0;
      rf_reg_in  = '0;
      rf_data_in = '0;
      if (any) begin
         if (sel_we) begin
            rf_wr      = 1'b1;
            rf_reg_in  = sel_addr;
            rf_data_in = sel_wdata;
         end else begin
            rf_rd      = 1'b1;
            rf_reg_out = sel_addr;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      own_id  = (state_q == ST_OWN1);
      if (any)
         last_d = sel;
      case (state_q)
         ST_IDLE: begin
            if (any && sel_lock) begin
               state_d = sel ? ST_OWN1 : ST_OWN0;
               cnt_d   = 8'd1;
            end
         end
         ST_OWN0, ST_OWN1: begin
            // Timeout is evaluated whether or not the owner is presenting a
            // beat, so an idle owner cannot starve the other side.
            if ((cnt_q >= 8'(MAX_LOCK)) || (any && !sel_lock)) begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
               last_d  = own_id;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_comb begin
      rvalid_d[0] = grant[REQ_CORE] & ~req0_we;
      rvalid_d[1] = grant[REQ_HOST] & ~req1_we;
      rdata0_d    = rvalid_d[0] ? rf_data_out : rdata0_q;
      rdata1_d    = rvalid_d[1] ? rf_data_out : rdata1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         last_q   <= REQ_HOST;
         rvalid_q <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         rvalid_q <= rvalid_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign req0_rvalid = rvalid_q[0];
   assign req1_rvalid = rvalid_q[1];
   assign req0_rdata  = rdata0_q;
   assign req1_rdata  = rdata1_q;
   assign owner       = {state_q != ST_IDLE, last_q};

endmodule
